// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single async-FIFO write port between two producers in the CLK
//   domain. Channel 0 carries one RegFile read byte per request. Channel 1
//   carries one ALU word per request, written low byte first. The two bytes
//   of a word are always consecutive FIFO entries.
//   Each channel has a one-entry holding slot, so producers fire and forget.
//   Arbitration is round-robin, and writes stall while FIFO_FULL is high.
//
// Handshake: a strobe (Rd_D_Valid / OUT_Valid) is a one-cycle request with no
//   ready. The data is captured if the slot is free. A slot also counts as
//   free in the cycle its last byte is written. A strobe that finds the slot
//   occupied is discarded and sets the sticky Drop_Err. On the FIFO side,
//   WR_INC is a valid strobe and !FIFO_FULL acts as ready. A byte is written
//   only in a cycle where both are true.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   Rd_D, Rd_D_Valid         channel-0 byte and request strobe
//   ALU_OUT, OUT_Valid       channel-1 word and request strobe
//   FIFO_FULL                FIFO backpressure
//   WR_INC, WR_DATA          FIFO write strobe / data (data is 0 when not writing)
//   Ch0_Busy, Ch1_Busy       slot occupied flags
//   Drop_Err                 sticky lost-request flag
//   Arb_Idle                 FSM idle and both slots empty
//   Arb_State                current FSM state, for observation

module fifo_wr_arbiter #(
  parameter int D_Width = 8,
  parameter int ALU_O_W = 2 * D_Width
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [D_Width-1:0] Rd_D,
  input  logic               Rd_D_Valid,
  input  logic [ALU_O_W-1:0] ALU_OUT,
  input  logic               OUT_Valid,
  input  logic               FIFO_FULL,
  output logic               WR_INC,
  output logic [D_Width-1:0] WR_DATA,
  output logic               Ch0_Busy,
  output logic               Ch1_Busy,
  output logic               Drop_Err,
  output logic               Arb_Idle,
  output logic [1:0]         Arb_State
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CH0_WR = 2'd1,
    CH1_LO = 2'd2,
    CH1_HI = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [D_Width-1:0] slot0;
  logic [ALU_O_W-1:0] slot1;
  logic               pending0;
  logic               pending1;
  logic               last_grant;
  logic               drop_err;
  logic               rel0;
  logic               rel1;

  // A slot is released in the cycle its final byte is accepted by the FIFO.
  assign rel0 = (state == CH0_WR) && !FIFO_FULL;
  assign rel1 = (state == CH1_HI) && !FIFO_FULL;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot0      <= '0;
      slot1      <= '0;
      pending0   <= 1'b0;
      pending1   <= 1'b0;
      drop_err   <= 1'b0;
      last_grant <= 1'b1;  // channel 0 wins the first tie
    end else begin
      // A releasing slot can be refilled in the same cycle.
      if (Rd_D_Valid && (!pending0 || rel0)) begin
        slot0    <= Rd_D;
        pending0 <= 1'b1;
      end else if (rel0) begin
        pending0 <= 1'b0;
      end

      if (OUT_Valid && (!pending1 || rel1)) begin
        slot1    <= ALU_OUT;
        pending1 <= 1'b1;
      end else if (rel1) begin
        pending1 <= 1'b0;
      end

      if ((Rd_D_Valid && pending0 && !rel0) ||
          (OUT_Valid && pending1 && !rel1)) begin
        drop_err <= 1'b1;
      end

      if (rel0) begin
        last_grant <= 1'b0;
      end else if (rel1) begin
        last_grant <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    WR_INC    = 1'b0;
    WR_DATA   = '0;
    case (state)
      IDLE: begin
        // A grant is made even when the FIFO is full. The granted state then waits.
        if (pending0 && (!pending1 || last_grant)) begin
          state_nxt = CH0_WR;
        end else if (pending1) begin
          state_nxt = CH1_LO;
        end
      end
      CH0_WR: begin
        if (!FIFO_FULL) begin
          WR_INC    = 1'b1;
          WR_DATA   = slot0;
          state_nxt = IDLE;
        end
      end
      CH1_LO: begin
        if (!FIFO_FULL) begin
          WR_INC    = 1'b1;
          WR_DATA   = slot1[D_Width-1:0];
          state_nxt = CH1_HI;
        end
      end
      CH1_HI: begin
        if (!FIFO_FULL) begin
          WR_INC    = 1'b1;
          WR_DATA   = slot1[ALU_O_W-1:D_Width];
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Ch0_Busy  = pending0;
  assign Ch1_Busy  = pending1;
  assign Drop_Err  = drop_err;
  assign Arb_Idle  = (state == IDLE) && !pending0 && !pending1;
  assign Arb_State = state;

endmodule
